// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, multi-cycle data-memory access with
// hazard stall, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic [31:0] BranchTarget_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  WriteReg_in,
    input  logic        Zero_in,
    output logic        PCSrc,
    output logic [31:0] BranchTarget_out,
    output logic        stall,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  WriteReg_out
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                regwrite_q, regwrite_d;
    logic                memtoreg_q, memtoreg_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [REG_W-1:0]    wreg_q, wreg_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   addr;
    logic                access;
    logic                mem_we;

    // Byte address to word address; low two bits and high bits dropped.
    assign addr   = ALUResult_in[ADDR_W+1:2];
    assign access = MemWrite_in | MemtoReg_in;

    assign PCSrc            = Branch_in & Zero_in;
    assign BranchTarget_out = BranchTarget_in;

    // Access sequencer: stall for MEM_LAT-1 cycles, complete on the last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && (MEM_LAT > 1)) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            stall   = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign mem_we = MemWrite_in & access & ~stall & ~reset;

    // MEM/WB next value: bubble while stalled, capture otherwise.
    always_comb begin
        regwrite_d = RegWrite_in;
        memtoreg_d = MemtoReg_in;
        rdata_d    = mem[addr];
        alu_d      = ALUResult_in;
        wreg_d     = WriteReg_in;
        if (stall) begin
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            rdata_d    = rdata_q;
            alu_d      = alu_q;
            wreg_d     = wreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdata_q    <= '0;
            alu_q      <= '0;
            wreg_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            rdata_q    <= rdata_d;
            alu_q      <= alu_d;
            wreg_q     <= wreg_d;
        end
    end

    // Data memory array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= WriteData_in;
        end
    end

    assign RegWrite_out  = regwrite_q;
    assign MemtoReg_out  = memtoreg_q;
    assign ReadData_out  = rdata_q;
    assign ALUResult_out = alu_q;
    assign WriteReg_out  = wreg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: three instances with MEM_LAT = 2, 4 and 1.
module tb_mem_stage;

    localparam int unsigned N_DUT = 3;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        branch;
        logic [31:0] target;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        zero;
    } op_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } res_t;

    typedef struct {
        res_t res;
        int   stalls;
        bit   chk;
    } exp_t;

    typedef struct {
        res_t res;
        int   stalls;
        bit   bad;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    op_t         din    [N_DUT];
    logic        rst    [N_DUT];
    logic        pcsrc  [N_DUT];
    logic        stall  [N_DUT];
    logic        rw_o   [N_DUT];
    logic        mr_o   [N_DUT];
    logic [31:0] bt_o   [N_DUT];
    logic [31:0] rd_o   [N_DUT];
    logic [31:0] alu_o  [N_DUT];
    logic [4:0]  wr_o   [N_DUT];

    logic [31:0] model [N_DUT][256];
    bit          known [N_DUT][256];
    exp_t        sb[$];
    obs_t        ob[$];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        mem_stage #(
            .DEPTH  (256),
            .ADDR_W (8),
            .MEM_LAT(g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk             (clk),
            .reset           (rst[g]),
            .RegWrite_in     (din[g].regwrite),
            .MemtoReg_in     (din[g].memtoreg),
            .MemWrite_in     (din[g].memwrite),
            .Branch_in       (din[g].branch),
            .BranchTarget_in (din[g].target),
            .ALUResult_in    (din[g].alu),
            .WriteData_in    (din[g].wdata),
            .WriteReg_in     (din[g].wreg),
            .Zero_in         (din[g].zero),
            .PCSrc           (pcsrc[g]),
            .BranchTarget_out(bt_o[g]),
            .stall           (stall[g]),
            .RegWrite_out    (rw_o[g]),
            .MemtoReg_out    (mr_o[g]),
            .ReadData_out    (rd_o[g]),
            .ALUResult_out   (alu_o[g]),
            .WriteReg_out    (wr_o[g])
        );
    end

    function automatic int lat(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    function automatic op_t mk(input logic rw, input logic mr, input logic mw,
                               input logic [31:0] alu, input logic [31:0] wdata,
                               input logic [4:0] wreg);
        op_t o;
        o = '0;
        o.regwrite = rw;
        o.memtoreg = mr;
        o.memwrite = mw;
        o.alu      = alu;
        o.wdata    = wdata;
        o.wreg     = wreg;
        return o;
    endfunction

    // Reference model: word address, pre-write read data, store update, latency.
    task automatic predict(input int d, input op_t op);
        exp_t       e;
        logic [7:0] a;
        a = op.alu[9:2];
        e.res.regwrite = op.regwrite;
        e.res.memtoreg = op.memtoreg;
        e.res.alu      = op.alu;
        e.res.wreg     = op.wreg;
        e.chk          = known[d][a];
        e.res.rdata    = known[d][a] ? model[d][a] : 32'h0;
        if (op.memwrite) begin
            model[d][a] = op.wdata;
            known[d][a] = 1'b1;
        end
        e.stalls = ((op.memwrite || op.memtoreg) && lat(d) > 1) ? lat(d) - 1 : 0;
        sb.push_back(e);
    endtask

    // Present one instruction, follow the stall, capture MEM/WB after completion.
    task automatic run_op(input int d, input op_t op);
        obs_t        o;
        logic [31:0] alu_prev, rd_prev;
        logic [4:0]  wr_prev;
        o.stalls = 0;
        o.bad    = 1'b0;
        @(negedge clk);
        din[d] = op;
        #1;
        alu_prev = alu_o[d];
        rd_prev  = rd_o[d];
        wr_prev  = wr_o[d];
        while (stall[d] === 1'b1) begin
            o.stalls++;
            if (o.stalls > 20) begin
                o.bad = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rw_o[d] !== 1'b0 || mr_o[d] !== 1'b0 || alu_o[d] !== alu_prev ||
                rd_o[d] !== rd_prev || wr_o[d] !== wr_prev)
                o.bad = 1'b1;
        end
        @(posedge clk);
        #1;
        o.res = {rw_o[d], mr_o[d], rd_o[d], alu_o[d], wr_o[d]};
        ob.push_back(o);
    endtask

    task automatic test_reset();
        for (int d = 0; d < N_DUT; d++) begin
            rst[d] = 1'b1;
            din[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        din[0] = mk(1'b0, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 5'd0);
        #1;
        checks++;
        if (stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b required 0", stall[0]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            checks++;
            if ({rw_o[d], mr_o[d], rd_o[d], alu_o[d], wr_o[d]} !== 71'h0) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: got rw=%b mr=%b rd=%h alu=%h wr=%0d required all 0",
                         d, rw_o[d], mr_o[d], rd_o[d], alu_o[d], wr_o[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
            rst[d] = 1'b0;
            din[d] = '0;
        end
    endtask

    task automatic test_rtype();
        exp_t e;
        obs_t o;
        predict(0, mk(1'b1, 1'b0, 1'b0, 32'h2A, 32'h0, 5'd5));
        run_op(0, mk(1'b1, 1'b0, 1'b0, 32'h2A, 32'h0, 5'd5));
        while (sb.size() > 0 && ob.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (!e.chk) o.res.rdata = 32'h0;
            checks++;
            if (o.res !== e.res) begin
                failures++;
                $display("FAIL rtype memwb: got %h required %h", o.res, e.res);
            end
            checks++;
            if (o.stalls != e.stalls || o.bad) begin
                failures++;
                $display("FAIL rtype stall: got %0d cycles bubble_err=%0d required %0d", o.stalls, o.bad, e.stalls);
            end
        end
    endtask

    task automatic test_store_load();
        op_t q[$];
        exp_t e;
        obs_t o;
        int   i;
        q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 5'd0));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd8));
        q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd9));
        foreach (q[k]) begin
            predict(0, q[k]);
            run_op(0, q[k]);
        end
        i = 0;
        while (sb.size() > 0 && ob.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (!e.chk) o.res.rdata = 32'h0;
            checks++;
            if (o.res !== e.res) begin
                failures++;
                $display("FAIL store_load memwb[%0d]: got %h required %h", i, o.res, e.res);
            end
            checks++;
            if (o.stalls != e.stalls || o.bad) begin
                failures++;
                $display("FAIL store_load stall[%0d]: got %0d cycles bubble_err=%0d required %0d", i, o.stalls, o.bad, e.stalls);
            end
            i++;
        end
    endtask

    task automatic test_wrap();
        op_t q[$];
        exp_t e;
        obs_t o;
        int   i;
        q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h403, 32'h11, 5'd0));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd2));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h8, 32'h77, 5'd0));
        q.push_back(mk(1'b0, 1'b1, 1'b1, 32'h8, 32'hA5, 5'd3));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0B, 32'h0, 5'd4));
        foreach (q[k]) begin
            predict(0, q[k]);
            run_op(0, q[k]);
        end
        i = 0;
        while (sb.size() > 0 && ob.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (!e.chk) o.res.rdata = 32'h0;
            checks++;
            if (o.res !== e.res) begin
                failures++;
                $display("FAIL wrap memwb[%0d]: got %h required %h", i, o.res, e.res);
            end
            checks++;
            if (o.stalls != e.stalls || o.bad) begin
                failures++;
                $display("FAIL wrap stall[%0d]: got %0d cycles bubble_err=%0d required %0d", i, o.stalls, o.bad, e.stalls);
            end
            i++;
        end
    endtask

    task automatic test_branch();
        logic [32:0] tbl [3];
        logic        br [3];
        logic        exp_pc;
        tbl[0] = {1'b1, 32'h40};
        tbl[1] = {1'b0, 32'h40};
        tbl[2] = {1'b1, 32'h80};
        br[0] = 1'b1;
        br[1] = 1'b1;
        br[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din[0]        = '0;
            din[0].branch = br[i];
            din[0].zero   = tbl[i][32];
            din[0].target = tbl[i][31:0];
            #1;
            exp_pc = br[i] & tbl[i][32];
            checks++;
            if (pcsrc[0] !== exp_pc) begin
                failures++;
                $display("FAIL branch_pcsrc[%0d]: got %b required %b", i, pcsrc[0], exp_pc);
            end
            checks++;
            if (bt_o[0] !== tbl[i][31:0]) begin
                failures++;
                $display("FAIL branch_target[%0d]: got %h required %h", i, bt_o[0], tbl[i][31:0]);
            end
            checks++;
            if (stall[0] !== 1'b0) begin
                failures++;
                $display("FAIL branch_stall[%0d]: got %b required 0", i, stall[0]);
            end
        end
        @(negedge clk);
        din[0] = '0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        int   i;
        predict(1, mk(1'b0, 1'b0, 1'b1, 32'h20, 32'h99, 5'd0));
        run_op(1, mk(1'b0, 1'b0, 1'b1, 32'h20, 32'h99, 5'd0));
        // Aborted store: not predicted, so the model keeps 0x99.
        @(negedge clk);
        din[1] = mk(1'b0, 1'b0, 1'b1, 32'h20, 32'h55, 5'd0);
        #1;
        checks++;
        if (stall[1] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid stall_c1: got %b required 1", stall[1]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (stall[1] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid stall_c2: got %b required 1", stall[1]);
        end
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        checks++;
        if (stall[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid stall_in_reset: got %b required 0", stall[1]);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pcsrc[1], rw_o[1], mr_o[1], rd_o[1], alu_o[1], wr_o[1]} !== 72'h0) begin
            failures++;
            $display("FAIL reset_mid outputs: got pc=%b rw=%b mr=%b rd=%h alu=%h wr=%0d required all 0",
                     pcsrc[1], rw_o[1], mr_o[1], rd_o[1], alu_o[1], wr_o[1]);
        end
        rst[1] = 1'b0;
        predict(1, mk(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd6));
        run_op(1, mk(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd6));
        i = 0;
        while (sb.size() > 0 && ob.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (!e.chk) o.res.rdata = 32'h0;
            checks++;
            if (o.res !== e.res) begin
                failures++;
                $display("FAIL reset_mid memwb[%0d]: got %h required %h", i, o.res, e.res);
            end
            checks++;
            if (o.stalls != e.stalls || o.bad) begin
                failures++;
                $display("FAIL reset_mid stall[%0d]: got %0d cycles bubble_err=%0d required %0d", i, o.stalls, o.bad, e.stalls);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        op_t q[$];
        exp_t e;
        obs_t o;
        int   i;
        q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h30, 32'h100, 5'd0));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 5'd10));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h30, 32'h200, 5'd0));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 5'd11));
        q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd12));
        foreach (q[k]) begin
            predict(2, q[k]);
            run_op(2, q[k]);
        end
        foreach (q[k]) begin
            predict(0, q[k]);
            run_op(0, q[k]);
        end
        i = 0;
        while (sb.size() > 0 && ob.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (!e.chk) o.res.rdata = 32'h0;
            checks++;
            if (o.res !== e.res) begin
                failures++;
                $display("FAIL back_to_back memwb[%0d]: got %h required %h", i, o.res, e.res);
            end
            checks++;
            if (o.stalls != e.stalls || o.bad) begin
                failures++;
                $display("FAIL back_to_back stall[%0d]: got %0d cycles bubble_err=%0d required %0d", i, o.stalls, o.bad, e.stalls);
            end
            i++;
        end
    endtask

    initial begin
        for (int d = 0; d < N_DUT; d++) begin
            for (int a = 0; a < 256; a++) begin
                known[d][a] = 1'b0;
                model[d][a] = 32'h0;
            end
        end
        test_reset();
        test_rtype();
        test_store_load();
        test_wrap();
        test_branch();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
